// File: rtl/rx_hash_assembler.sv
// Frame assembler behind the serial receive buffer: waits for a sync byte, collects NUM_BYTES payload
// bytes into a target hash and hands it over with valid/ack. Optional trailing XOR checksum: RX_HASH_CHECKSUM_EN.
module rx_hash_assembler #(
    parameter int         NUM_BYTES      = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     rx_data,
    input  logic                           data_ready,
    input  logic                           overrun_error,
    input  logic                           hash_ack,
    output logic [8*NUM_BYTES-1:0]         target_hash,
    output logic                           hash_valid,
    output logic                           frame_error,
    output logic                           busy,
    output logic [$clog2(NUM_BYTES+1)-1:0] byte_count
);

    localparam int HW = 8 * NUM_BYTES;
    localparam int CW = $clog2(NUM_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef RX_HASH_CHECKSUM_EN
    localparam int SW = HW;
`else
    // Without the checksum the final byte is taken straight from rx_data, so only NUM_BYTES-1 are held.
    localparam int SW = HW - 8;
`endif

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic [HW-1:0]   target_hash_q, target_hash_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   byte_count_q, byte_count_d;
    logic            frame_error_q, frame_error_d;

    logic in_frame, sync_seen, last_byte, timeout_hit, abort;

`ifdef RX_HASH_CHECKSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [HW-1:0] v);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) r = r ^ v[8*i +: 8];
        return r;
    endfunction

    logic csum_ok;
    assign csum_ok = (rx_data == xor_bytes(shift_q));
`endif

    assign in_frame    = (state_q == S_COLLECT) || (state_q == S_CHECK);
    assign sync_seen   = data_ready && (rx_data == SYNC_BYTE);
    assign last_byte   = (byte_count_q == CW'(NUM_BYTES - 1));
    // An arriving byte always beats the timeout; the timer trips on the idle cycle that would reach the limit.
    assign timeout_hit = !data_ready && (timer_q >= TW'(TIMEOUT_CYCLES - 1));
    assign abort       = overrun_error || timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (sync_seen) state_d = S_COLLECT;
            S_COLLECT: begin
                if (abort)                        state_d = S_IDLE;
`ifdef RX_HASH_CHECKSUM_EN
                else if (data_ready && last_byte) state_d = S_CHECK;
`else
                else if (data_ready && last_byte) state_d = S_DONE;
`endif
            end
`ifdef RX_HASH_CHECKSUM_EN
            S_CHECK: begin
                if (abort)           state_d = S_IDLE;
                else if (data_ready) state_d = csum_ok ? S_DONE : S_IDLE;
            end
`endif
            S_DONE:    if (hash_ack) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = in_frame;
        hash_valid = (state_q == S_DONE);
    end

    always_comb begin
        shift_d       = shift_q;
        target_hash_d = target_hash_q;
        timer_d       = timer_q;
        byte_count_d  = byte_count_q;
        frame_error_d = 1'b0;
        if (in_frame) begin
            if (abort) begin
                frame_error_d = 1'b1;
                byte_count_d  = '0;
                timer_d       = '0;
            end else if (data_ready) begin
                timer_d = '0;
                if (state_q == S_COLLECT) begin
                    shift_d      = SW'({shift_q, rx_data});
                    byte_count_d = byte_count_q + CW'(1);
`ifndef RX_HASH_CHECKSUM_EN
                    if (last_byte) target_hash_d = {shift_q, rx_data};
`endif
                end
`ifdef RX_HASH_CHECKSUM_EN
                else if (csum_ok) begin
                    target_hash_d = shift_q;
                end else begin
                    frame_error_d = 1'b1;
                    byte_count_d  = '0;
                end
`endif
            end else begin
                timer_d = (timer_q == TW'(TIMEOUT_CYCLES)) ? timer_q : timer_q + TW'(1);
            end
        end else if ((state_q == S_IDLE) && sync_seen) begin
            byte_count_d = '0;
            timer_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q       <= '0;
            target_hash_q <= '0;
            timer_q       <= '0;
            byte_count_q  <= '0;
            frame_error_q <= 1'b0;
        end else begin
            shift_q       <= shift_d;
            target_hash_q <= target_hash_d;
            timer_q       <= timer_d;
            byte_count_q  <= byte_count_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign target_hash = target_hash_q;
    assign byte_count  = byte_count_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_rx_hash_assembler.sv
// Bench for rx_hash_assembler: directed frames plus random traffic, checked every cycle against a
// queue-based frame model; also exercises the RX_HASH_CHECKSUM_EN build when that macro is defined.
module tb_rx_hash_assembler;

    localparam int NB = 16;
    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         data_ready;
    logic         overrun_error;
    logic         hash_ack;
    logic [127:0] target_hash;
    logic         hash_valid;
    logic         frame_error;
    logic         busy;
    logic [4:0]   byte_count;

    rx_hash_assembler #(
        .NUM_BYTES(NB),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .data_ready(data_ready),
        .overrun_error(overrun_error),
        .hash_ack(hash_ack),
        .target_hash(target_hash),
        .hash_valid(hash_valid),
        .frame_error(frame_error),
        .busy(busy),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 idle, 1 collecting, 2 awaiting checksum, 3 holding a hash
    int           m_mode = 0;
    logic [7:0]   m_bytes[$];
    int           m_idle = 0;
    logic [127:0] m_hash = '0;
    logic         m_ferr = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xor_all();
        logic [7:0] x = 8'h00;
        foreach (m_bytes[i]) x ^= m_bytes[i];
        return x;
    endfunction

    task automatic m_abort();
        m_mode = 0;
        m_ferr = 1'b1;
        m_bytes.delete();
        m_idle = 0;
    endtask

    task automatic m_finish();
        logic [127:0] h = '0;
        foreach (m_bytes[i]) h = {h[119:0], m_bytes[i]};
        m_hash = h;
        m_mode = 3;
    endtask

    task automatic m_reset();
        m_mode = 0;
        m_bytes.delete();
        m_idle = 0;
        m_hash = '0;
        m_ferr = 1'b0;
    endtask

    task automatic m_edge(input logic dr, input logic [7:0] d, input logic ovr, input logic ack);
        m_ferr = 1'b0;
        case (m_mode)
            0: if (dr && d == 8'hA5) begin
                m_mode = 1;
                m_bytes.delete();
                m_idle = 0;
            end
            1, 2: begin
                if (ovr) m_abort();
                else if (dr) begin
                    m_idle = 0;
                    if (m_mode == 1) begin
                        m_bytes.push_back(d);
                        if (m_bytes.size() == NB) begin
`ifdef RX_HASH_CHECKSUM_EN
                            m_mode = 2;
`else
                            m_finish();
`endif
                        end
                    end else if (d == xor_all()) m_finish();
                    else m_abort();
                end else begin
                    m_idle++;
                    if (m_idle >= TO) m_abort();
                end
            end
            3: if (ack) m_mode = 0;
            default: m_mode = 0;
        endcase
    endtask

    task automatic compare_all();
        check("target_hash", target_hash, m_hash);
        check("hash_valid", hash_valid, m_mode == 3);
        check("frame_error", frame_error, m_ferr);
        check("busy", busy, (m_mode == 1) || (m_mode == 2));
        if (m_mode != 0 || m_ferr) check("byte_count", byte_count, m_bytes.size());
    endtask

    // One clock: drive inputs, step the model at the edge, sample 1 ns later
    task automatic cyc(input logic dr, input logic [7:0] d, input logic ovr, input logic ack);
        data_ready    = dr;
        rx_data       = d;
        overrun_error = ovr;
        hash_ack      = ack;
        @(posedge clk);
        if (rst) m_reset();
        else     m_edge(dr, d, ovr, ack);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Sync + NB random payload bytes with short random gaps, plus a correct checksum when enabled
    task automatic send_good_frame();
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        send(8'hA5);
        for (int i = 0; i < NB; i++) begin
            b = 8'($urandom);
            x ^= b;
            send(b);
            idle(int'($urandom_range(0, 2)));
        end
`ifdef RX_HASH_CHECKSUM_EN
        send(x);
`endif
    endtask

    initial begin
        rst = 1'b1;
        data_ready = 1'b0; rx_data = 8'h00; overrun_error = 1'b0; hash_ack = 1'b0;

        // Reset held while clocking
        idle(3);
        check("rst_byte_count", byte_count, 5'd0);
        rst = 1'b0;
        idle(2);

        // Nominal frame: stray byte, sync, payload 00..0F
        send(8'h3C);
        send(8'hA5);
        for (int i = 0; i < NB; i++) send(8'(i));
`ifdef RX_HASH_CHECKSUM_EN
        send(8'h00);
`endif
        check("nominal_hash", target_hash, 128'h000102030405060708090A0B0C0D0E0F);
        check("nominal_valid", hash_valid, 1'b1);
        idle(2);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("ack_clears_valid", hash_valid, 1'b0);

        // Overrun abort on top of a data_ready, then a clean frame
        send(8'hA5);
        for (int i = 0; i < 5; i++) send(8'($urandom));
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        check("ovr_pulse", frame_error, 1'b1);
        check("ovr_count", byte_count, 5'd0);
        check("ovr_hash_kept", target_hash, 128'h000102030405060708090A0B0C0D0E0F);
        idle(1);
        check("ovr_pulse_one_cycle", frame_error, 1'b0);
        send_good_frame();
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Timeout after TO idle cycles, then a byte landing exactly on idle cycle TO
        send(8'hA5);
        for (int i = 0; i < 3; i++) send(8'($urandom));
        idle(TO);
        check("timeout_pulse", frame_error, 1'b1);
        check("timeout_idle", busy, 1'b0);
        send(8'hA5);
        for (int i = 0; i < 3; i++) send(8'($urandom));
        idle(TO - 1);
        send(8'h5A);
        check("late_byte_no_err", frame_error, 1'b0);
        check("late_byte_count", byte_count, 5'd4);
        for (int i = 0; i < NB - 4; i++) send(8'($urandom));
`ifdef RX_HASH_CHECKSUM_EN
        send(xor_all());
`endif
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // DONE hold: a whole second frame without ack is ignored; sync with ack is dropped too
        send_good_frame();
        send(8'hA5);
        for (int i = 0; i < NB; i++) send(8'($urandom));
        cyc(1'b1, 8'h00, 1'b1, 1'b0);
        check("hold_valid", hash_valid, 1'b1);
        cyc(1'b1, 8'hA5, 1'b0, 1'b1);
        check("ack_sync_dropped", busy, 1'b0);
        idle(1);

`ifdef RX_HASH_CHECKSUM_EN
        // Bad checksum: frame rejected, previous hash kept
        send(8'hA5);
        for (int i = 0; i < NB; i++) send(8'(i));
        send(8'h01);
        check("csum_bad_err", frame_error, 1'b1);
        check("csum_bad_valid", hash_valid, 1'b0);
        idle(1);
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 2) == 0,
                (($urandom % 4) == 0) ? 8'hA5 : 8'($urandom),
                ($urandom % 24) == 0,
                ($urandom % 8) == 0);
            if (($urandom % 50) == 0) idle(int'($urandom_range(5, TO + 2)));
        end

        // Asynchronous reset mid-frame takes effect without a clock edge
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        send_good_frame();
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        send(8'hA5);
        for (int i = 0; i < 4; i++) send(8'($urandom));
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_count", byte_count, 5'd0);
        check("arst_hash", target_hash, 128'h0);
        check("arst_valid", hash_valid, 1'b0);
        m_reset();
        idle(1);
        rst = 1'b0;
        send_good_frame();
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
